obuf_drain_reader: RTL and testbench

- Read-side sequencer for the 128x32 1R1W output buffer SRAM.
- On a start command it walks the SRAM read port from a start address for a programmed number of words.
- It captures each returned word and streams it downstream over a valid/ready handshake.
- It sits between the output buffer and the result-egress logic. It never drives the SRAM write port.

---
 rtl/obuf_drain_reader.sv | 98 +++++++++
 tb/tb_obuf_drain_reader.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/obuf_drain_reader.sv
// obuf_drain_reader: walks the output-buffer SRAM read port and streams the words out over valid/ready
module obuf_drain_reader #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] StartAddress,
  input  logic [ADDR_WIDTH:0]   WordCount,
  output logic [ADDR_WIDTH-1:0] ReadAddress,
  input  logic [DATA_WIDTH-1:0] ReadBus,
  output logic [DATA_WIDTH-1:0] OutData,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic                  Busy,
  output logic                  Done
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH + 1)'(1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;
  state_t r_state, w_next;
  logic [ADDR_WIDTH:0] r_remaining, w_left;
  logic [ADDR_WIDTH-1:0] r_next_addr, r_read_addr, w_addr;
  logic r_inflight, r_busy, r_done;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic w_pop, w_room, w_issue;
  assign ReadAddress = r_read_addr;
  assign OutValid = r_count != '0;
  assign OutData = r_mem[r_rptr];
  assign Busy = r_busy;
  assign Done = r_done;
  assign w_pop = OutValid & OutReady;
  // A pop this cycle frees a slot for the word that lands next cycle, which keeps 1 word/clock.
  assign w_room = (r_count + CW'(r_inflight)) < (CW'(FIFO_DEPTH) + CW'(w_pop));
  // The first read goes out on the same edge the start is accepted.
  assign w_addr = (r_state == IDLE) ? StartAddress : r_next_addr;
  assign w_left = ((r_state == IDLE) ? WordCount : r_remaining) - ONE;
  // Next-state and read-issue decision
  always_comb begin
    w_next = r_state;
    w_issue = 1'b0;
    case (r_state)
      IDLE: begin
        w_issue = start && (WordCount != '0);
        w_next = !start ? IDLE : (WordCount == '0) ? FINISH : (WordCount == ONE) ? DRAIN : ISSUE;
      end
      ISSUE: begin
        w_issue = w_room;
        w_next = (w_room && r_remaining == ONE) ? DRAIN : ISSUE;
      end
      DRAIN: w_next = (!r_inflight && r_count == '0) ? FINISH : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  // Sequencer state, read address generation and status flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_remaining <= '0;
      r_next_addr <= '0;
      r_read_addr <= '0;
      r_inflight <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_next;
      r_inflight <= w_issue;
      r_done <= r_state == FINISH;
      r_busy <= (r_state == IDLE) ? start : (r_state != FINISH);
      if (w_issue) begin
        r_read_addr <= w_addr;
        r_next_addr <= w_addr + ADDR_WIDTH'(1);
        r_remaining <= w_left;
      end
    end
  end
  // Skid FIFO: capture the word one edge after its address was registered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (r_inflight) begin
        r_mem[r_wptr] <= ReadBus;
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(r_inflight) - CW'(w_pop);
    end
  end
endmodule

// File: tb/tb_obuf_drain_reader.sv
// tb_obuf_drain_reader: directed checks of the SRAM drain sequencer
module tb_obuf_drain_reader;
  logic clock, reset, start, OutReady, OutValid, Busy, Done;
  logic [6:0] StartAddress, ReadAddress;
  logic [7:0] WordCount;
  logic [31:0] ReadBus, OutData;
  logic [31:0] sram [128];
  logic [31:0] got [$];
  logic [6:0] addrs [$];
  int checks, errors, dones, first_v, last_t, done_c;
  logic busy0, busy_done;
  bit pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  obuf_drain_reader dut (
    .clock(clock), .reset(reset), .start(start), .StartAddress(StartAddress),
    .WordCount(WordCount), .ReadAddress(ReadAddress), .ReadBus(ReadBus),
    .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady), .Busy(Busy), .Done(Done)
  );

  assign ReadBus = sram[ReadAddress];
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_data(input string tag, input logic [6:0] sa, input int n);
    logic [6:0] a;
    check({tag, "_len"}, got.size(), n);
    for (int i = 0; i < n; i++) begin
      a = sa + 7'(i);
      check(tag, i < got.size() ? got[i] : 32'hDEAD_BEEF, 32'h100 + {25'd0, a});
    end
  endtask

  task automatic run(input logic [6:0] sa, input logic [7:0] wc, input bit bp, input int mid, input int budget);
    int tail, issued;
    logic [6:0] last;
    logic pv, pr;
    logic [31:0] pd;
    got.delete();
    addrs.delete();
    dones = 0; first_v = -1; last_t = -1; done_c = -1; busy0 = 0; busy_done = 1;
    tail = 0; issued = 0; last = ReadAddress; pv = 0; pr = 0; pd = '0;
    StartAddress = sa; WordCount = wc; start = 1;
    @(posedge clock); #1;
    start = 0;
    for (int c = 0; c < budget && tail < 4; c++) begin
      OutReady = bp ? pat[c % 5] : 1'b1;
      if (c == mid) begin
        StartAddress = sa + 7'd40;
        WordCount = 8'd3;
        start = 1;
      end
      @(negedge clock);
      if (c == 0) busy0 = Busy;
      if (ReadAddress != last) begin
        issued++;
        addrs.push_back(ReadAddress);
        last = ReadAddress;
      end
      if (bp) check("ahead", {31'd0, issued <= got.size() + 2}, 32'd1);
      if (pv && !pr) begin
        check("stall_valid", {31'd0, OutValid}, 32'd1);
        check("stall_data", OutData, pd);
      end
      if (OutValid && first_v < 0) first_v = c;
      if (OutValid && OutReady) begin
        got.push_back(OutData);
        last_t = c;
      end
      if (Done) begin
        dones++;
        if (done_c < 0) begin
          done_c = c;
          busy_done = Busy;
        end
      end
      if (dones > 0) tail++;
      pv = OutValid; pr = OutReady; pd = OutData;
      @(posedge clock); #1;
      start = 0;
    end
    if (done_c < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    checks = 0; errors = 0;
    clock = 0; reset = 1; start = 0; OutReady = 0; StartAddress = '0; WordCount = '0;
    for (int i = 0; i < 128; i++) sram[i] = 32'h100 + i;
    #12;
    check("rst_addr", {25'd0, ReadAddress}, 32'd0);
    check("rst_data", OutData, 32'd0);
    check("rst_valid", {31'd0, OutValid}, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    @(posedge clock); #1;
    reset = 0;

    run(7'd5, 8'd4, 1'b0, -1, 60);
    check_data("basic", 7'd5, 4);
    check("basic_first_valid", first_v, 1);
    check("basic_last_xfer", last_t, 4);
    check("basic_busy", {31'd0, busy0}, 32'd1);
    check("basic_done_cnt", dones, 1);
    check("basic_done_after", {31'd0, done_c > last_t}, 32'd1);
    check("basic_busy_at_done", {31'd0, busy_done}, 32'd0);

    run(7'd0, 8'd6, 1'b1, -1, 100);
    check_data("bp", 7'd0, 6);
    check("bp_done_cnt", dones, 1);

    run(7'd126, 8'd4, 1'b0, -1, 60);
    check_data("wrap", 7'd126, 4);
    check("wrap_addr_n", addrs.size(), 4);
    check("wrap_a0", addrs.size() > 0 ? {25'd0, addrs[0]} : 32'hFFFF, 32'd126);
    check("wrap_a1", addrs.size() > 1 ? {25'd0, addrs[1]} : 32'hFFFF, 32'd127);
    check("wrap_a2", addrs.size() > 2 ? {25'd0, addrs[2]} : 32'hFFFF, 32'd0);
    check("wrap_a3", addrs.size() > 3 ? {25'd0, addrs[3]} : 32'hFFFF, 32'd1);

    run(7'd33, 8'd0, 1'b0, -1, 30);
    check("zero_words", got.size(), 0);
    check("zero_valid", first_v, -1);
    check("zero_busy", {31'd0, busy0}, 32'd1);
    check("zero_done_cyc", done_c, 1);
    check("zero_busy_at_done", {31'd0, busy_done}, 32'd0);
    check("zero_done_cnt", dones, 1);

    run(7'd64, 8'd128, 1'b0, -1, 400);
    check_data("full", 7'd64, 128);
    check("full_done_cnt", dones, 1);

    run(7'd10, 8'd5, 1'b0, 2, 60);
    check_data("busy_start", 7'd10, 5);
    check("busy_start_done_cnt", dones, 1);

    StartAddress = 7'd20; WordCount = 8'd10; start = 1;
    @(posedge clock); #1;
    start = 0; OutReady = 0;
    repeat (3) begin
      @(posedge clock); #1;
    end
    check("pre_rst_valid", {31'd0, OutValid}, 32'd1);
    check("pre_rst_busy", {31'd0, Busy}, 32'd1);
    @(negedge clock); #2;
    reset = 1;
    #1;
    check("arst_valid", {31'd0, OutValid}, 32'd0);
    check("arst_busy", {31'd0, Busy}, 32'd0);
    check("arst_done", {31'd0, Done}, 32'd0);
    check("arst_addr", {25'd0, ReadAddress}, 32'd0);
    @(posedge clock); #1;
    reset = 0; OutReady = 1;
    dones = 0;
    repeat (6) begin
      @(negedge clock);
      if (Done || OutValid) dones++;
    end
    check("arst_quiet", dones, 0);
    @(posedge clock); #1;
    run(7'd40, 8'd3, 1'b0, -1, 60);
    check_data("after_rst", 7'd40, 3);
    check("after_rst_done_cnt", dones, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
